demux16_scan_ctrl: RTL and testbench
====================================

Name: demux16_scan_ctrl

Overview:
- Sequencing controller for the 1x16 demux datapath.
- Steps the 4-bit select through the channels enabled in a 16-bit mask, in ascending order with wrap-around, holding each channel for DWELL cycles.
- Routes the 1-bit input onto the selected output line, registered.
- Sits between a serial 1-bit source and 16 per-channel consumers; reports busy and end-of-frame.

Parameters:
- DWELL, default 4: cycles spent on each enabled channel; legal range 1..256.
- CNT_W, default 8: dwell counter width; must satisfy 2^CNT_W >= DWELL.

Ports:
- clk  input  1: single clock, rising edge.
- rst  input  1: synchronous, active-high reset.
- start  input  1: one-cycle request to begin scanning. Sampled only in IDLE.
- stop  input  1: request to end scanning. Sampled in SCAN.
- en_mask  input  16: channel enable mask. Latched on an accepted start.
- din  input  1: serial data to distribute.
- sel  output  4: current channel index.
- y  output  16: demux outputs; at most one bit may be high.
- busy  output  1: high while in SCAN.
- frame_done  output  1: one-cycle pulse when the last enabled channel's dwell completes.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - sel=0, y=0, busy=0, frame_done=0.
  - dwell counter=0, latched mask=0, stop-pending flag=0.
  - rst has priority over every other input, including mid-dwell; the next cycle is IDLE with all outputs 0.
- States: IDLE, SCAN.
- IDLE:
  - y=0, busy=0, sel holds its last value.
  - start=1 with en_mask!=0:
    - Latch the mask.
    - sel <= index of the lowest set bit.
    - Counter <= 0; go to SCAN.
    - busy is high from the next cycle.
  - start=1 with en_mask==0: ignored; stay IDLE.
- SCAN:
  - Each cycle: y <= din << sel, using the current sel.
    - Output latency: one cycle from din to y.
    - y is one-hot or zero.
  - Counter increments each cycle. When the counter reaches DWELL-1 (end of dwell):
    - Counter <= 0.
    - sel <= next set bit of the latched mask strictly above sel. If none exists, wrap to the lowest set bit.
    - If the move wraps, or only one bit is set, frame_done=1 for exactly that one cycle, registered with the sel change.
  - stop=1 in any SCAN cycle sets a stop-pending flag; the current dwell completes.
  - At the end of dwell with the flag set:
    - Go to IDLE; busy <= 0; y <= 0 on the next edge; flag cleared.
    - frame_done still pulses if that dwell was the frame's last.
  - start in SCAN is ignored. en_mask changes in SCAN are ignored until the next accepted start.
  - Simultaneous stop and end of dwell in the same cycle: return to IDLE at that edge.
- Single-channel mask: sel is constant; frame_done pulses every DWELL cycles.
- DWELL=1: sel advances every cycle.
- Arithmetic:
  - Counter is CNT_W bits unsigned; comparison is against DWELL-1.
  - Next-channel search is a priority scan over 16 bits. It is combinational, with no extra latency.

Decomposition:
- Shared package, demux_pkg:
  - Constants N_CH=16 and SEL_W=4.
  - State enum {IDLE, SCAN}.
  - A function returning the next set index above a given index, with wrap.
- Sub-module demux1x16_reg: registered 1x16 demux with ports clk, rst, en, din, sel, y.
  - en=0 forces y=0.
  - The controller drives en=busy.

Test Plan:
- Reset: assert rst for 2 cycles mid-SCAN with mask 16'hFFFF → next cycle sel=0, y=0, busy=0, frame_done=0; a start is needed to resume.
- Full scan, DWELL=4, mask 16'hFFFF, din=1:
  - sel steps 0,1,…,15, each held 4 cycles.
  - y = 16'h0001, 16'h0002, … 16'h8000, each lagging sel by 1 cycle.
  - frame_done pulses once, 64 cycles after start, when sel wraps 15→0.
- Sparse mask 16'h8421, DWELL=2:
  - sel sequence 0,5,10,15,0,…
  - frame_done on each 15→0 wrap, every 8 cycles.
  - Toggling din shows on y[sel] one cycle later.
- Single channel: mask 16'h0040, DWELL=3 → sel stays 6; frame_done every 3 cycles; y alternates 16'h0040/16'h0000 with din.
- Start with mask 16'h0000 → stays IDLE, busy=0, y=0.
- Stop: pulse stop in the 2nd cycle of channel 3's dwell (DWELL=4, mask 16'hFFFF) → sel stays 3 until the dwell ends, then IDLE, busy=0, y=0; no frame_done.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1x16 demux scan datapath: channel geometry,
// controller states and the next-enabled-channel search.
package demux_pkg;

    localparam int N_CH  = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Lowest set bit of mask strictly above cur; if none, the lowest set bit
    // overall (wrap). Returns 0 for an empty mask.
    function automatic logic [SEL_W-1:0] next_set(input logic [N_CH-1:0] mask,
                                                  input logic [SEL_W-1:0] cur);
        logic [SEL_W-1:0] above;
        logic [SEL_W-1:0] lowest;
        logic             hit;
        above  = '0;
        lowest = '0;
        hit    = 1'b0;
        // Walk downwards so the last match written is the lowest index.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = SEL_W'(i);
                if (i > int'(cur)) begin
                    above = SEL_W'(i);
                    hit   = 1'b1;
                end
            end
        end
        return hit ? above : lowest;
    endfunction

endpackage

// File: rtl/demux1x16_reg.sv
// Registered 1x16 demux: din is steered onto line sel of y one cycle later.
// With en low the outputs are held at zero.
module demux1x16_reg
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  y
);

    // Output register: one-hot copy of din on the selected line, or all zero.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            y <= '0;
        end else if (en) begin
            y <= N_CH'(din) << sel;
        end else begin
            y <= '0;
        end
    end

endmodule

// File: rtl/demux16_scan_ctrl.sv
// Scan controller for the 1x16 demux: walks the enabled channels of a
// latched mask in ascending order with wrap, dwelling DWELL cycles on each,
// and flags the end of every frame.
module demux16_scan_ctrl
    import demux_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [N_CH-1:0]  en_mask,
    input  logic             din,
    output logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  y,
    output logic             busy,
    output logic             frame_done
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic             stop_q, stop_d;
    logic             fd_q, fd_d;

    logic [SEL_W-1:0] nxt;
    logic             dwell_end;

    assign nxt       = next_set(mask_q, sel_q);
    assign dwell_end = (cnt_q == CNT_W'(DWELL - 1));

    // Next-state logic: start acceptance, dwell counting, channel stepping,
    // frame-end detection and deferred stop.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        stop_d  = stop_q;
        fd_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (en_mask != '0)) begin
                    mask_d  = en_mask;
                    sel_d   = next_set(en_mask, SEL_W'(N_CH - 1));
                    cnt_d   = '0;
                    stop_d  = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (dwell_end) begin
                    cnt_d = '0;
                    sel_d = nxt;
                    // A move to an equal or lower index is a wrap; a
                    // single-channel mask lands back on itself.
                    fd_d  = (nxt <= sel_q);
                    if (stop_q || stop) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                    end
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    stop_d = stop_q | stop;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            stop_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            stop_q  <= stop_d;
            fd_q    <= fd_d;
        end
    end

    assign busy       = (state_q == SCAN);
    assign sel        = sel_q;
    assign frame_done = fd_q;

    demux1x16_reg u_demux (
        .clk (clk),
        .rst (rst),
        .en  (busy),
        .din (din),
        .sel (sel_q),
        .y   (y)
    );

endmodule

// File: tb/tb_demux16_scan_ctrl.sv
// Bench for demux16_scan_ctrl: three instances (DWELL 4, 2, 3); a
// channel-list reference model pushes the expected post-edge outputs to a
// scoreboard queue which is popped and compared after each edge.
module tb_demux16_scan_ctrl;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] y;
        logic        busy;
        logic        fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] en_mask;
    logic        din;
    logic        start_v [3];
    logic        stop_v  [3];
    logic [3:0]  sel_v   [3];
    logic [15:0] y_v     [3];
    logic        busy_v  [3];
    logic        fd_v    [3];

    always #5 clk = ~clk;

    demux16_scan_ctrl #(.DWELL(4), .CNT_W(8)) u_d4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .stop(stop_v[0]),
        .en_mask(en_mask), .din(din), .sel(sel_v[0]), .y(y_v[0]),
        .busy(busy_v[0]), .frame_done(fd_v[0]));

    demux16_scan_ctrl #(.DWELL(2), .CNT_W(8)) u_d2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .stop(stop_v[1]),
        .en_mask(en_mask), .din(din), .sel(sel_v[1]), .y(y_v[1]),
        .busy(busy_v[1]), .frame_done(fd_v[1]));

    demux16_scan_ctrl #(.DWELL(3), .CNT_W(8)) u_d3 (
        .clk(clk), .rst(rst), .start(start_v[2]), .stop(stop_v[2]),
        .en_mask(en_mask), .din(din), .sel(sel_v[2]), .y(y_v[2]),
        .busy(busy_v[2]), .frame_done(fd_v[2]));

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int fd_seen  = 0;

    // Reference model state
    int          dwell_of [3] = '{4, 2, 3};
    logic        m_busy, m_fd, m_stop;
    logic [3:0]  m_sel;
    logic [15:0] m_y;
    int          m_cnt, m_pos;
    int          chans [$];
    exp_t        sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic model_step(input int id, input logic s_start, input logic s_stop,
                              input logic s_din, input logic [15:0] s_mask, input logic s_rst);
        if (s_rst) begin
            m_busy = 1'b0; m_sel = '0; m_y = '0; m_fd = 1'b0;
            m_cnt = 0; m_stop = 1'b0; m_pos = 0;
            chans.delete();
        end else if (!m_busy) begin
            m_y  = '0;
            m_fd = 1'b0;
            if (s_start && s_mask != 16'h0) begin
                chans.delete();
                for (int i = 0; i < 16; i++) if (s_mask[i]) chans.push_back(i);
                m_pos  = 0;
                m_sel  = 4'(chans[0]);
                m_cnt  = 0;
                m_stop = 1'b0;
                m_busy = 1'b1;
            end
        end else begin
            m_y    = s_din ? (16'd1 << m_sel) : 16'd0;
            m_fd   = 1'b0;
            m_stop = m_stop | s_stop;
            if (m_cnt == dwell_of[id] - 1) begin
                m_cnt = 0;
                m_pos = (m_pos + 1) % chans.size();
                m_sel = 4'(chans[m_pos]);
                m_fd  = (m_pos == 0);
                if (m_stop) begin
                    m_busy = 1'b0;
                    m_stop = 1'b0;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    // Drive one cycle of stimulus to instance id, push the expectation,
    // then compare the DUT outputs just after the edge.
    task automatic step(input int id, input logic s_start, input logic s_stop,
                        input logic s_din, input logic [15:0] s_mask, input logic s_rst);
        exp_t e, o;
        @(negedge clk);
        rst     = s_rst;
        en_mask = s_mask;
        din     = s_din;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = (i == id) && s_start;
            stop_v[i]  = (i == id) && s_stop;
        end
        model_step(id, s_start, s_stop, s_din, s_mask, s_rst);
        e.sel = m_sel; e.y = m_y; e.busy = m_busy; e.fd = m_fd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check($sformatf("sel[%0d]@%0d", id, cyc),  sel_v[id],  o.sel);
        check($sformatf("y[%0d]@%0d", id, cyc),    y_v[id],    o.y);
        check($sformatf("busy[%0d]@%0d", id, cyc), busy_v[id], o.busy);
        check($sformatf("fd[%0d]@%0d", id, cyc),   fd_v[id],   o.fd);
        if (fd_v[id]) fd_seen++;
        cyc++;
    endtask

    initial begin
        logic s_stop;
        rst = 1'b1; en_mask = '0; din = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            stop_v[i]  = 1'b0;
        end

        // Reset mid-scan, then no restart without start
        step(0, 0, 0, 0, 16'h0000, 1);
        step(0, 1, 0, 1, 16'hFFFF, 0);
        repeat (10) step(0, 0, 0, 1, 16'hFFFF, 0);
        repeat (2)  step(0, 0, 0, 1, 16'hFFFF, 1);
        repeat (4)  step(0, 0, 0, 1, 16'hFFFF, 0);

        // Full scan, DWELL=4, all channels, din=1: one frame end in 70 cycles
        step(0, 0, 0, 0, 16'h0000, 1);
        fd_seen = 0;
        step(0, 1, 0, 1, 16'hFFFF, 0);
        repeat (70) step(0, 0, 0, 1, 16'hFFFF, 0);
        check("full_fd_count", fd_seen, 1);

        // Sparse mask, DWELL=2, random din; a start mid-scan is ignored
        step(1, 0, 0, 0, 16'h0000, 1);
        step(1, 1, 0, 0, 16'h8421, 0);
        fd_seen = 0;
        for (int k = 1; k <= 24; k++)
            step(1, (k == 5), 0, 1'($urandom_range(0, 1)), (k == 5) ? 16'hFFFF : 16'h8421, 0);
        check("sparse_fd_count", fd_seen, 3);

        // Single channel 6, DWELL=3, alternating din
        step(2, 0, 0, 0, 16'h0000, 1);
        step(2, 1, 0, 0, 16'h0040, 0);
        fd_seen = 0;
        for (int k = 1; k <= 12; k++) step(2, 0, 0, 1'(k % 2), 16'h0040, 0);
        check("single_fd_count", fd_seen, 4);

        // Start with an empty mask stays idle
        step(0, 0, 0, 0, 16'h0000, 1);
        step(0, 1, 0, 1, 16'h0000, 0);
        repeat (4) step(0, 0, 0, 1, 16'h0000, 0);

        // Stop in the 2nd cycle of channel 3's dwell
        step(0, 0, 0, 0, 16'h0000, 1);
        step(0, 1, 0, 1, 16'hFFFF, 0);
        fd_seen = 0;
        repeat (30) begin
            s_stop = m_busy && (m_sel == 4'd3) && (m_cnt == 1);
            step(0, 0, s_stop, 1, 16'hFFFF, 0);
        end
        check("stop_fd_count", fd_seen, 0);
        check("stop_idle_busy", busy_v[0], 1'b0);
        check("stop_idle_y", y_v[0], 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
